// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared types and register map for the MMIO UART transmitter.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic TXDATA_OFF = 1'b0;
  localparam logic STATUS_OFF = 1'b1;

  localparam int FULL    = 0;
  localparam int EMPTY   = 1;
  localparam int BUSY    = 2;
  localparam int OVF     = 3;
  localparam int CNT_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_mmio_if                                                      |
// | Core data-memory port as seen by the UART peripheral.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_tx_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Sel;

  modport master (
    output MemWrite, ALUResult, WriteData,
    input  ReadData, Sel
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData,
    output ReadData, Sel
  );
endinterface
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_fifo                                                            |
// | Byte-wide synchronous FIFO; push is accepted when full if popping.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [7:0]             i_din,
  output logic [7:0]             o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_mmio                                                         |
// | Memory-mapped 8N1 UART transmitter with TX FIFO and STATUS register. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_mmio_if.slave bus,
  output logic          tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t          r_state, w_state_n;
  logic [BW-1:0]   r_bcnt, w_bcnt_n;
  logic [2:0]      r_bidx, w_bidx_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_tx, w_tx_n;
  logic            r_ovf;

  logic            w_sel, w_off, w_push, w_stat_wr, w_pop;
  logic            w_full, w_empty, w_bit_end;
  logic [7:0]      w_dout;
  logic [CW-1:0]   w_count;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_sel     = (bus.ALUResult[31:3] == BASE_ADDR[31:3]);
  assign w_off     = bus.ALUResult[2];
  assign w_push    = bus.MemWrite & w_sel & (w_off == TXDATA_OFF);
  assign w_stat_wr = bus.MemWrite & w_sel & (w_off == STATUS_OFF);
  assign w_unused  = &{1'b0, bus.ALUResult[1:0], bus.WriteData[31:8]};

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.WriteData[7:0]),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_stat_wr && bus.WriteData[OVF]) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_status              = '0;
    w_status[FULL]        = w_full;
    w_status[EMPTY]       = w_empty;
    w_status[BUSY]        = (r_state != IDLE);
    w_status[OVF]         = r_ovf;
    w_status[CNT_LSB +: 8] = 8'(w_count);
  end

  assign bus.Sel      = w_sel;
  assign bus.ReadData = (w_sel && w_off == STATUS_OFF) ? w_status : 32'h0;

  assign w_bit_end = (r_bcnt == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_bcnt  <= w_bcnt_n;
      r_bidx  <= w_bidx_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_bcnt_n  = r_bcnt;
    w_bidx_n  = r_bidx;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    w_tx_n    = 1'b1;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_dout;
          w_bcnt_n  = '0;
          w_state_n = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_bcnt_n  = '0;
          w_bidx_n  = '0;
          w_state_n = DATA;
        end else begin
          w_bcnt_n = r_bcnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_bcnt_n  = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bidx == 3'd7) w_state_n = STOP;
          else                w_bidx_n  = r_bidx + 1'b1;
        end else begin
          w_bcnt_n = r_bcnt + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_bcnt_n = '0;
          // Back-to-back frames: reload straight into START with no idle bit.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_dout;
            w_state_n = START;
          end else begin
            w_state_n = IDLE;
          end
        end else begin
          w_bcnt_n = r_bcnt + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
    // Line level follows the state being entered so tx comes from a flop.
    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

  assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_mmio                                                      |
// | Directed self-checking bench for the MMIO UART transmitter.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          CPB  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.ALUResult = a;
    bus.WriteData = d;
    tick();
    bus.MemWrite  = 1'b0;
    bus.ALUResult = 32'h0;
    bus.WriteData = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.MemWrite  = 1'b0;
    bus.ALUResult = a;
    #1;
    d = bus.ReadData;
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    logic [31:0] v;
    rd(BASE + 32'd4, v);
    chk(tag, v, exp);
  endtask

  // Walks the remaining cycles of one 8N1 frame, starting at frame cycle 'first'.
  task automatic frame(input logic [7:0] b, input int first, input string tag);
    logic [31:0] v;
    logic        e;
    for (int c = first; c < 10 * CPB; c++) begin
      tick();
      if (c < CPB)          e = 1'b0;
      else if (c >= 9 * CPB) e = 1'b1;
      else                  e = b[(c / CPB) - 1];
      chk($sformatf("%s tx c%0d", tag, c), {31'b0, tx}, {31'b0, e});
      rd(BASE + 32'd4, v);
      chk($sformatf("%s busy c%0d", tag, c), {31'b0, v[2]}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] v;
    logic        saw_low;
    bus.MemWrite  = 1'b0;
    bus.ALUResult = 32'h0;
    bus.WriteData = 32'h0;

    // 1: reset state
    repeat (3) tick();
    chk("rst tx", {31'b0, tx}, 32'd1);
    chk_status("rst status", 32'h0000_0002);
    chk("rst sel", {31'b0, bus.Sel}, 32'd1);
    rd(BASE, v);
    chk("rst txdata rd", v, 32'h0);
    reset = 1'b1;
    tick();
    chk("post rst tx", {31'b0, tx}, 32'd1);

    // 2: single frame 0xA5
    wr(BASE, 32'hFFFF_FFA5);
    chk("t2 tx before k+1", {31'b0, tx}, 32'd1);
    frame(8'hA5, 0, "t2");
    tick();
    chk_status("t2 status idle", 32'h0000_0002);
    chk("t2 tx idle", {31'b0, tx}, 32'd1);

    // 3: two frames with no gap
    wr(BASE, 32'h11);
    wr(BASE, 32'h22);
    chk("t3 start c0", {31'b0, tx}, 32'd0);
    frame(8'h11, 1, "t3a");
    frame(8'h22, 0, "t3b");
    tick();
    chk_status("t3 status idle", 32'h0000_0002);

    // 4: fill FIFO, overflow, clear, drain in order
    for (int i = 0; i < 10; i++) begin
      wr(BASE, i);
      if (i == 1) chk_status("t4 after pop", 32'h0000_0104);
    end
    chk_status("t4 full ovf", 32'h0000_080D);
    wr(BASE + 32'd4, 32'h8);
    chk_status("t4 ovf cleared", 32'h0000_0805);
    frame(8'h00, 10, "t4f0");
    for (int i = 1; i <= 8; i++) frame(8'(i), 0, $sformatf("t4f%0d", i));
    tick();
    chk_status("t4 drained", 32'h0000_0002);
    chk("t4 tx idle", {31'b0, tx}, 32'd1);

    // 5: write outside the window
    bus.MemWrite  = 1'b1;
    bus.ALUResult = BASE + 32'd8;
    bus.WriteData = 32'h55;
    #1;
    chk("t5 sel", {31'b0, bus.Sel}, 32'd0);
    chk("t5 rdata", bus.ReadData, 32'h0);
    tick();
    bus.MemWrite = 1'b0;
    saw_low = 1'b0;
    repeat (8) begin
      tick();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    chk("t5 tx stays high", {31'b0, saw_low}, 32'd0);
    chk_status("t5 status", 32'h0000_0002);

    // 6: reset during data bit 3 with two bytes queued
    wr(BASE, 32'hA5);
    wr(BASE, 32'hC3);
    wr(BASE, 32'h3C);
    repeat (16) tick();
    chk("t6 tx bit3", {31'b0, tx}, 32'd0);
    chk_status("t6 status pre", 32'h0000_0204);
    reset = 1'b0;
    tick();
    chk("t6 tx after rst", {31'b0, tx}, 32'd1);
    chk_status("t6 status in rst", 32'h0000_0002);
    reset = 1'b1;
    saw_low = 1'b0;
    repeat (60) begin
      tick();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    chk("t6 no more frames", {31'b0, saw_low}, 32'd0);
    chk_status("t6 status end", 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
